// File: rtl/dot_eater.sv
// Dot consumer: maps the player position to a tile, eats the dot there, and keeps
// the remaining-dot count, a saturating score and a sticky level-clear flag.
module dot_eater #(
    parameter int unsigned DOT_POINTS = 10,
    parameter int unsigned SCORE_W    = 16,
    localparam int unsigned TILE_NUM  = 24 * 32,
    localparam int unsigned WIDTH     = 640,
    localparam int unsigned HEIGHT    = 480,
    localparam int unsigned X_W       = $clog2(WIDTH),
    localparam int unsigned Y_W       = $clog2(HEIGHT),
    localparam int unsigned CNT_W     = 10,
    parameter logic [TILE_NUM-1:0] INIT_DOTS = '1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                move_tick,
    input  logic [X_W-1:0]      x,
    input  logic [Y_W-1:0]      y,
    input  logic                restart,
    output logic [TILE_NUM-1:0] tilemap_dots,
    output logic [CNT_W-1:0]    dots_left,
    output logic [SCORE_W-1:0]  score,
    output logic                eat_pulse,
    output logic                level_clear,
    output logic                busy
);
    localparam int unsigned TILE_SIZE    = 20;
    localparam int unsigned TILE_COL_NUM = 32;
    localparam int unsigned IDX_W        = 10;
    localparam int unsigned SUM_W        = SCORE_W + 32;
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    function automatic logic [CNT_W-1:0] popcount(input logic [TILE_NUM-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < TILE_NUM; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

    localparam logic [CNT_W-1:0] INIT_COUNT = popcount(INIT_DOTS);

    typedef enum logic [1:0] {IDLE, CHECK, CLEAR, SCORE} state_t;

    state_t            state;
    logic [IDX_W-1:0]  idx;

    logic              in_range_c;
    logic [IDX_W-1:0]  tick_idx_c;
    logic [SUM_W-1:0]  score_sum_c;
    logic [SCORE_W-1:0] score_next_c;

    // Tile lookup from the sprite's top-left pixel
    assign in_range_c = (x < X_W'(WIDTH)) && (y < Y_W'(HEIGHT));
    assign tick_idx_c = IDX_W'(y / Y_W'(TILE_SIZE)) * IDX_W'(TILE_COL_NUM)
                      + IDX_W'(x / X_W'(TILE_SIZE));

    // Widened add so the clamp sees any carry out of the score
    assign score_sum_c  = SUM_W'(score) + SUM_W'(DOT_POINTS);
    assign score_next_c = (score_sum_c > SUM_W'(SCORE_MAX)) ? SCORE_MAX
                                                            : score_sum_c[SCORE_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            idx          <= '0;
            tilemap_dots <= INIT_DOTS;
            dots_left    <= INIT_COUNT;
            score        <= '0;
            eat_pulse    <= 1'b0;
            level_clear  <= 1'b0;
            busy         <= 1'b0;
        end else if (restart) begin
            state        <= IDLE;
            tilemap_dots <= INIT_DOTS;
            dots_left    <= INIT_COUNT;
            eat_pulse    <= 1'b0;
            level_clear  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            eat_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    // Ticks arriving while busy are simply dropped
                    if (move_tick && in_range_c) begin
                        idx   <= tick_idx_c;
                        state <= CHECK;
                        busy  <= 1'b1;
                    end
                end
                CHECK: begin
                    if (tilemap_dots[idx]) begin
                        state <= CLEAR;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                CLEAR: begin
                    tilemap_dots[idx] <= 1'b0;
                    dots_left         <= dots_left - CNT_W'(1);
                    eat_pulse         <= 1'b1;
                    state             <= SCORE;
                end
                SCORE: begin
                    score <= score_next_c;
                    if (dots_left == '0) begin
                        level_clear <= 1'b1;
                    end
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dot_eater.sv
// Randomized bench for dot_eater: three instances (default, sparse bitmap, 4-bit
// score) share one stimulus stream and are compared against a timeline model.
module tb_dot_eater;
    localparam int unsigned TILES = 768;
    localparam logic [TILES-1:0] ALL_INIT = '1;
    localparam logic [TILES-1:0] LC_INIT  = {1'b1, 766'b0, 1'b1};

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       move_tick = 1'b0;
    logic [9:0] x = '0;
    logic [8:0] y = '0;
    logic       restart = 1'b0;

    logic [TILES-1:0] bits_a, bits_b, bits_c;
    logic [9:0]       dots_a, dots_b, dots_c;
    logic [15:0]      score_a, score_b;
    logic [3:0]       score_c;
    logic             eat_a, eat_b, eat_c, lc_a, lc_b, lc_c, busy_a, busy_b, busy_c;

    always #5 clk = ~clk;

    dot_eater u_def (
        .clk(clk), .reset(reset), .move_tick(move_tick), .x(x), .y(y), .restart(restart),
        .tilemap_dots(bits_a), .dots_left(dots_a), .score(score_a),
        .eat_pulse(eat_a), .level_clear(lc_a), .busy(busy_a)
    );

    dot_eater #(.INIT_DOTS(LC_INIT)) u_lc (
        .clk(clk), .reset(reset), .move_tick(move_tick), .x(x), .y(y), .restart(restart),
        .tilemap_dots(bits_b), .dots_left(dots_b), .score(score_b),
        .eat_pulse(eat_b), .level_clear(lc_b), .busy(busy_b)
    );

    dot_eater #(.SCORE_W(4), .DOT_POINTS(10)) u_sat (
        .clk(clk), .reset(reset), .move_tick(move_tick), .x(x), .y(y), .restart(restart),
        .tilemap_dots(bits_c), .dots_left(dots_c), .score(score_c),
        .eat_pulse(eat_c), .level_clear(lc_c), .busy(busy_c)
    );

    logic [TILES-1:0] o_bits  [3];
    logic [15:0]      o_score [3];
    logic [9:0]       o_dots  [3];
    logic             o_eat [3], o_lc [3], o_busy [3];

    assign o_bits[0] = bits_a;  assign o_bits[1] = bits_b;  assign o_bits[2] = bits_c;
    assign o_dots[0] = dots_a;  assign o_dots[1] = dots_b;  assign o_dots[2] = dots_c;
    assign o_score[0] = score_a; assign o_score[1] = score_b; assign o_score[2] = 16'(score_c);
    assign o_eat[0] = eat_a;    assign o_eat[1] = eat_b;    assign o_eat[2] = eat_c;
    assign o_lc[0] = lc_a;      assign o_lc[1] = lc_b;      assign o_lc[2] = lc_c;
    assign o_busy[0] = busy_a;  assign o_busy[1] = busy_b;  assign o_busy[2] = busy_c;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [TILES-1:0] got, input logic [TILES-1:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: per instance, committed state plus one in-flight tick
    logic [TILES-1:0] m_bits [3];
    int  m_dots [3];
    int  m_score [3];
    int  m_max [3] = '{65535, 65535, 15};
    int  m_pend [3] = '{-1, -1, -1};
    int  m_idx [3];
    bit  m_hit [3];
    bit  m_lc [3];
    bit  checking = 1'b0;

    int  cyc = 0;
    bit  s_tick, s_restart, s_reset;
    int  s_x, s_y;

    function automatic logic [TILES-1:0] init_of(input int k);
        return (k == 1) ? LC_INIT : ALL_INIT;
    endfunction

    always @(posedge clk) begin
        cyc       = cyc + 1;
        s_tick    = move_tick;
        s_restart = restart;
        s_reset   = reset;
        s_x       = int'(x);
        s_y       = int'(y);
    end

    always @(negedge clk) begin
        if (s_reset) checking = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bit exp_eat;
            bit exp_busy;
            bit idle;
            if (s_reset) begin
                m_bits[k]  = init_of(k);
                m_dots[k]  = $countones(init_of(k));
                m_score[k] = 0;
                m_lc[k]    = 1'b0;
                m_pend[k]  = -1;
            end else if (s_restart) begin
                m_bits[k] = init_of(k);
                m_dots[k] = $countones(init_of(k));
                m_lc[k]   = 1'b0;
                m_pend[k] = -1;
            end else begin
                idle = (m_pend[k] < 0) || (cyc - 1 >= m_pend[k] + (m_hit[k] ? 4 : 2));
                if (s_tick && s_x < 640 && s_y < 480 && idle) begin
                    m_pend[k] = cyc - 1;
                    m_idx[k]  = (s_y / 20) * 32 + s_x / 20;
                    m_hit[k]  = m_bits[k][m_idx[k]];
                end
            end
            exp_eat = 1'b0;
            if (m_pend[k] >= 0 && m_hit[k]) begin
                if (cyc == m_pend[k] + 3) begin
                    m_bits[k][m_idx[k]] = 1'b0;
                    m_dots[k] = m_dots[k] - 1;
                    exp_eat   = 1'b1;
                end
                if (cyc == m_pend[k] + 4) begin
                    m_score[k] = (m_score[k] + 10 > m_max[k]) ? m_max[k] : m_score[k] + 10;
                    if (m_dots[k] == 0) m_lc[k] = 1'b1;
                end
            end
            exp_busy = (m_pend[k] >= 0) && (cyc >= m_pend[k] + 1)
                    && (cyc <= m_pend[k] + (m_hit[k] ? 3 : 1));
            if (checking) begin
                check($sformatf("c%0d u%0d bitmap", cyc, k), o_bits[k], m_bits[k]);
                check($sformatf("c%0d u%0d dots_left", cyc, k), TILES'(o_dots[k]), TILES'(m_dots[k]));
                check($sformatf("c%0d u%0d score", cyc, k), TILES'(o_score[k]), TILES'(m_score[k]));
                check($sformatf("c%0d u%0d eat_pulse", cyc, k), TILES'(o_eat[k]), TILES'(exp_eat));
                check($sformatf("c%0d u%0d level_clear", cyc, k), TILES'(o_lc[k]), TILES'(m_lc[k]));
                check($sformatf("c%0d u%0d busy", cyc, k), TILES'(o_busy[k]), TILES'(exp_busy));
            end
        end
    end

    task automatic step(input bit t, input int xx, input int yy, input bit rs, input bit rst);
        move_tick = t;
        x         = 10'(xx);
        y         = 9'(yy);
        restart   = rs;
        reset     = rst;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_n(input int n);
        repeat (n) step(1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic tick_at(input int xx, input int yy);
        step(1'b1, xx, yy, 1'b0, 1'b0);
    endtask

    initial begin
        step(1'b0, 0, 0, 1'b0, 1'b1);
        step(1'b0, 0, 0, 1'b0, 1'b1);
        idle_n(3);
        // hit on tile 34, then a miss on the same tile
        tick_at(45, 30);   idle_n(6);
        tick_at(45, 30);   idle_n(4);
        // first and last tiles: clears the sparse instance's level
        tick_at(0, 0);     idle_n(6);
        tick_at(639, 479); idle_n(6);
        tick_at(639, 479); idle_n(4);
        // second tick lands while busy and is dropped
        tick_at(20, 0);
        tick_at(40, 0);    idle_n(6);
        tick_at(640, 0);   idle_n(3);
        tick_at(0, 480);   idle_n(3);
        // restart during CLEAR, reset during SCORE
        tick_at(100, 100); idle_n(1);
        step(1'b0, 0, 0, 1'b1, 1'b0); idle_n(5);
        tick_at(200, 200); idle_n(2);
        step(1'b0, 0, 0, 1'b0, 1'b1); idle_n(4);
        // restart wins over a simultaneous tick
        step(1'b1, 300, 300, 1'b1, 1'b0); idle_n(4);
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 2)       step(1'b0, 0, 0, 1'b1, 1'b0);
            else if (r == 2) step(1'b0, 0, 0, 1'b0, 1'b1);
            else if (r < 45) tick_at(int'($urandom_range(0, 700)), int'($urandom_range(0, 511)));
            else             idle_n(1);
        end
        idle_n(6);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/dot_eater.md
# dot_eater

Downstream consumer of the player-movement stage. Each time the player position updates, it maps the player's (x, y) to a tile index and checks the dot bitmap it owns. If a dot is present, it clears the dot, decrements the remaining-dot count and adds points to a saturating score. It drives `tilemap_dots` back to the movement and render stages and raises `level_clear` when the last dot is eaten.

## Interface
Parameters:
- `DOT_POINTS`, default 10: points added per dot eaten.
- `INIT_DOTS`, default all-ones (`tile_row_num*tile_col_num` bits): dot bitmap loaded on reset/restart. Bit i = tile i.
- `SCORE_W`, default 16: score width.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  reset; one clock, synchronous, active-high.
- `move_tick`  in  1  one-cycle pulse; player position has just been updated.
- `x`  in  `$clog2(WIDTH)` (10)  player pixel x, top-left of sprite.
- `y`  in  `$clog2(HEIGHT)` (9)  player pixel y.
- `restart`  in  1  synchronous; reload `INIT_DOTS`, keep score.
- `tilemap_dots`  out  `tile_row_num*tile_col_num` (768)  current dot bitmap.
- `dots_left`  out  10  number of set bits in `tilemap_dots`.
- `score`  out  `SCORE_W`  accumulated points.
- `eat_pulse`  out  1  one-cycle strobe per dot eaten (sound/FX).
- `level_clear`  out  1  sticky; all dots eaten.
- `busy`  out  1  high when FSM not in IDLE.

## Operation
- Tile index = `(y / tile_size) * tile_col_num + x / tile_size`. With `tile_size`=20 and `tile_col_num`=32, index is 0..767.
- Index arithmetic is done at 10 bits.
- If `x >= WIDTH` or `y >= HEIGHT`, the tick is ignored and the FSM stays in IDLE.
- FSM states: IDLE, CHECK, CLEAR, SCORE.
  - IDLE: on `move_tick` with in-range position, register the index and go to CHECK.
  - CHECK: if `tilemap_dots[idx]` is 1, go to CLEAR; otherwise go to IDLE.
  - CLEAR: clear `tilemap_dots[idx]`, decrement `dots_left`, assert `eat_pulse`; go to SCORE.
  - SCORE: `score <= min(score + DOT_POINTS, 2^SCORE_W - 1)`; deassert `eat_pulse`; set `level_clear` if `dots_left == 0`; go to IDLE.
- `move_tick` while `busy` is dropped, not queued. The movement stage ticks no faster than once per 4 cycles.
- `dots_left` never underflows: CLEAR is only reachable when a set bit exists.
- `restart` (reset not asserted) from any state:
  - `tilemap_dots <= INIT_DOTS`, `dots_left <= popcount(INIT_DOTS)`.
  - `level_clear <= 0`, `eat_pulse <= 0`, state to IDLE.
  - Score unchanged.
- `reset` from any state, including mid-operation:
  - `tilemap_dots = INIT_DOTS`, `dots_left = popcount(INIT_DOTS)` (elaboration-time constant).
  - `score = 0`, `eat_pulse = 0`, `level_clear = 0`, state IDLE, `busy = 0`.
- `reset` has priority over `restart`; `restart` has priority over `move_tick`.
- Once `level_clear` is set, further ticks still run the FSM but find no dots.

## Timing
- `move_tick` sampled in cycle N; `x`/`y` sampled in the same cycle only.
- `busy` is high in cycles N+1..N+3 on a hit and in cycle N+1 only on a miss.
- On a hit:
  - Cycle N+3: `tilemap_dots` bit cleared, `dots_left` decremented, `eat_pulse` high for exactly that cycle.
  - Cycle N+4: `score` updated and `level_clear` valid.
- Earliest accepted next tick: cycle N+2 on a miss, cycle N+4 on a hit.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Reset values:** assert `reset` 2 cycles with `INIT_DOTS` = all ones -> `dots_left`=768, `score`=0, `tilemap_dots` all ones, `eat_pulse`=0, `level_clear`=0, `busy`=0.
- **Single hit:** tick at x=45, y=30 -> idx 34. Bit 34 clears in N+3, `eat_pulse` high 1 cycle, `dots_left`=767, `score`=10 at N+4. Repeat tick at the same position -> miss, `score` stays 10, `busy` high only 1 cycle.
- **Level clear:** `INIT_DOTS` with only bits 0 and 767 set. Tick at (0,0), then (639,479) -> `dots_left` 2->1->0; `level_clear` rises at N+4 of the 2nd tick and stays high.
- **Busy drop and out-of-range:** tick at (20,0), then a second tick at (40,0) in N+1 -> bit 2 untouched, only bit 1 cleared. Tick at x=640 -> no state change, `busy` stays 0.
- **Saturation:** `SCORE_W`=4, `DOT_POINTS`=10. Two hits -> `score` 10 then 15, no wrap.
- **Restart and reset mid-op:** `restart` in CLEAR cycle -> bitmap reloaded, score kept, `eat_pulse`=0. `reset` in SCORE cycle -> `score`=0, state IDLE next cycle.
